// File: rtl/lap_stopwatch.sv
// Lap stopwatch: centisecond/second/minute counter with run/pause/idle control and a lap FIFO.
// Define LAP_STOPWATCH_SPLIT_EN to store split times (elapsed since previous lap) instead of absolute times.
module lap_stopwatch #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned MIN_W       = 7,
  parameter int unsigned MIN_MAX     = 59,
  parameter int unsigned SATURATE    = 0,
  parameter int unsigned LAP_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_stop,
  input  logic                clear,
  input  logic                lap,
  output logic [6:0]          cs_count,
  output logic [6:0]          sec_count,
  output logic [MIN_W-1:0]    min_count,
  output logic                running,
  output logic                max_flag,
  output logic                lap_valid,
  input  logic                lap_ready,
  output logic [14+MIN_W-1:0] lap_data,
  output logic                lap_overflow
);

  localparam int unsigned DIV    = CLK_FREQ_HZ / 100;
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W  = $clog2(LAP_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned DATA_W = 14 + MIN_W;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   div;
  logic               tick;
  logic               at_max;
  logic               sat_en;

  assign sat_en  = (SATURATE != 0);
  assign tick    = (state == RUN) && (div == DIV_W'(DIV - 1));
  assign at_max  = (cs_count == 7'd99) && (sec_count == 7'd59) &&
                   (min_count == MIN_W'(MIN_MAX));
  assign running = (state == RUN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_stop) state_next = RUN;
      RUN:     if (start_stop || (tick && at_max && sat_en)) state_next = PAUSE;
      PAUSE: begin
        if (clear) state_next = IDLE;
        else if (start_stop && !(sat_en && max_flag)) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Divider only advances in RUN; holding it in PAUSE keeps the sub-centisecond phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      cs_count  <= '0;
      sec_count <= '0;
      min_count <= '0;
      max_flag  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE || (state == PAUSE && clear)) begin
        div       <= '0;
        cs_count  <= '0;
        sec_count <= '0;
        min_count <= '0;
        max_flag  <= 1'b0;
      end else if (tick) begin
        div <= '0;
        if (at_max) begin
          max_flag <= 1'b1;
          if (!sat_en) begin
            cs_count  <= '0;
            sec_count <= '0;
            min_count <= '0;
          end
        end else if (cs_count == 7'd99) begin
          cs_count <= '0;
          if (sec_count == 7'd59) begin
            sec_count <= '0;
            min_count <= min_count + 1'b1;
          end else begin
            sec_count <= sec_count + 7'd1;
          end
        end else begin
          cs_count <= cs_count + 7'd1;
        end
      end else if (state == RUN) begin
        div <= div + 1'b1;
      end
    end
  end

  logic [DATA_W-1:0] mem [LAP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              push, pop, full, empty, accept, drop;
  logic [DATA_W-1:0] entry;

  assign empty     = (occ == '0);
  assign full      = (occ == OCC_W'(LAP_DEPTH));
  assign lap_valid = !empty;
  assign push      = lap && (state != IDLE);
  assign pop       = lap_valid && lap_ready;
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign lap_data  = lap_valid ? mem[rd_ptr] : '0;

`ifdef LAP_STOPWATCH_SPLIT_EN
  localparam int unsigned MW1 = MIN_W + 1;

  logic [6:0]       ref_cs, ref_sec;
  logic [MIN_W-1:0] ref_min;
  logic [7:0]       cs_diff, sec_diff;
  logic [MIN_W:0]   min_diff;
  logic             b_cs, b_sec;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      ref_cs  <= '0;
      ref_sec <= '0;
      ref_min <= '0;
    end else if (accept) begin
      ref_cs  <= cs_count;
      ref_sec <= sec_count;
      ref_min <= min_count;
    end
  end

  // Mixed-radix subtract; the minute field wraps modulo MIN_MAX+1 after a rollover.
  always_comb begin
    cs_diff = {1'b0, cs_count} - {1'b0, ref_cs};
    b_cs    = cs_diff[7];
    if (b_cs) cs_diff = cs_diff + 8'd100;
    sec_diff = {1'b0, sec_count} - {1'b0, ref_sec} - {7'd0, b_cs};
    b_sec    = sec_diff[7];
    if (b_sec) sec_diff = sec_diff + 8'd60;
    min_diff = {1'b0, min_count} - {1'b0, ref_min} - {{MIN_W{1'b0}}, b_sec};
    if (min_diff[MIN_W]) min_diff = min_diff + MW1'(MIN_MAX + 1);
  end

  assign entry = {min_diff[MIN_W-1:0], sec_diff[6:0], cs_diff[6:0]};
`else
  assign entry = {min_count, sec_count, cs_count};
`endif

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      lap_overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      occ <= occ + 1'b1;
      else if (!accept && pop) occ <= occ - 1'b1;
      if (clear && empty) lap_overflow <= 1'b0;
      else if (drop)      lap_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Randomized and directed bench for lap_stopwatch: three configurations checked every cycle
// against a total-centisecond reference model with an array-based lap FIFO.
module tb_lap_stopwatch;

  localparam int NI = 3;
  localparam int P_DIV   [NI] = '{10, 1, 1};
  localparam int P_MM    [NI] = '{59, 1, 0};
  localparam int P_SAT   [NI] = '{0, 0, 1};
  localparam int P_DEPTH [NI] = '{4, 4, 2};

  logic clk = 1'b0;
  logic rst = 1'b1, start_stop = 1'b0, clear = 1'b0, lap = 1'b0, lap_ready = 1'b0;

  logic [6:0]  cs_o   [NI];
  logic [6:0]  sec_o  [NI];
  logic [6:0]  min_o  [NI];
  logic        run_o  [NI];
  logic        max_o  [NI];
  logic        val_o  [NI];
  logic [20:0] data_o [NI];
  logic        ovf_o  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lap_stopwatch #(.CLK_FREQ_HZ(1000), .MIN_W(7), .MIN_MAX(59), .SATURATE(0), .LAP_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .cs_count(cs_o[0]), .sec_count(sec_o[0]), .min_count(min_o[0]), .running(run_o[0]),
    .max_flag(max_o[0]), .lap_valid(val_o[0]), .lap_ready(lap_ready), .lap_data(data_o[0]),
    .lap_overflow(ovf_o[0]));

  lap_stopwatch #(.CLK_FREQ_HZ(100), .MIN_W(7), .MIN_MAX(1), .SATURATE(0), .LAP_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .cs_count(cs_o[1]), .sec_count(sec_o[1]), .min_count(min_o[1]), .running(run_o[1]),
    .max_flag(max_o[1]), .lap_valid(val_o[1]), .lap_ready(lap_ready), .lap_data(data_o[1]),
    .lap_overflow(ovf_o[1]));

  lap_stopwatch #(.CLK_FREQ_HZ(100), .MIN_W(7), .MIN_MAX(0), .SATURATE(1), .LAP_DEPTH(2)) u_c (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .cs_count(cs_o[2]), .sec_count(sec_o[2]), .min_count(min_o[2]), .running(run_o[2]),
    .max_flag(max_o[2]), .lap_valid(val_o[2]), .lap_ready(lap_ready), .lap_data(data_o[2]),
    .lap_overflow(ovf_o[2]));

  // Reference model: time as total centiseconds, state 0=idle 1=run 2=pause.
  int          m_st  [NI];
  int          m_ph  [NI];
  int          m_t   [NI];
  int          m_ref [NI];
  int          m_n   [NI];
  bit          m_max [NI];
  bit          m_ovf [NI];
  logic [20:0] m_q   [NI][4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [20:0] pack_time(input int t);
    logic [6:0] c, s, m;
    c = 7'(t % 100);
    s = 7'((t / 100) % 60);
    m = 7'(t / 6000);
    return {m, s, c};
  endfunction

  task automatic model_step(input int i);
    int period, st0, n0;
    logic [20:0] entry;
    bit push, pop;
    if (rst) begin
      m_st[i] = 0; m_ph[i] = 0; m_t[i] = 0; m_ref[i] = 0; m_n[i] = 0;
      m_max[i] = 0; m_ovf[i] = 0;
      return;
    end
    period = (P_MM[i] + 1) * 6000;
    st0 = m_st[i];
    n0  = m_n[i];
`ifdef LAP_STOPWATCH_SPLIT_EN
    entry = pack_time((m_t[i] - m_ref[i] + period) % period);
`else
    entry = pack_time(m_t[i]);
`endif
    push = lap && (st0 != 0);
    pop  = (n0 > 0) && lap_ready;
    if (pop) begin
      for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
      m_n[i]--;
    end
    if (push) begin
      if (n0 == P_DEPTH[i] && !pop) m_ovf[i] = 1;
      else begin
        m_q[i][m_n[i]] = entry;
        m_n[i]++;
        m_ref[i] = m_t[i];
      end
    end
    if (clear && n0 == 0) m_ovf[i] = 0;
    if (st0 == 0) m_ref[i] = 0;
    case (st0)
      0: begin
        m_ph[i] = 0;
        if (start_stop) m_st[i] = 1;
      end
      1: begin
        if (m_ph[i] == P_DIV[i] - 1) begin
          m_ph[i] = 0;
          if (m_t[i] == period - 1) begin
            m_max[i] = 1;
            if (P_SAT[i] != 0) m_st[i] = 2;
            else m_t[i] = 0;
          end else begin
            m_t[i]++;
          end
        end else begin
          m_ph[i]++;
        end
        if (start_stop) m_st[i] = 2;
      end
      default: begin
        if (clear) begin
          m_st[i] = 0; m_t[i] = 0; m_ph[i] = 0; m_max[i] = 0;
        end else if (start_stop && !(P_SAT[i] != 0 && m_max[i])) begin
          m_st[i] = 1;
        end
      end
    endcase
  endtask

  function automatic logic [63:0] obs(input int i);
    return {18'd0, min_o[i], sec_o[i], cs_o[i], run_o[i], max_o[i], val_o[i], data_o[i], ovf_o[i]};
  endfunction

  function automatic logic [63:0] expv(input int i);
    logic [20:0] head;
    head = (m_n[i] > 0) ? m_q[i][0] : 21'd0;
    return {18'd0, pack_time(m_t[i]), m_st[i] == 1, m_max[i], m_n[i] > 0, head, m_ovf[i]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("model_cfg%0d", i), obs(i), expv(i));
    @(negedge clk);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; cyc(); start_stop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lap_cs [5];
    int w;
    lap_cs = '{5, 12, 20, 33, 41};
    @(negedge clk);
    repeat (3) cyc();
    check("reset_state", obs(0), 64'd0);
    rst = 1'b0;

    // Divider 10: first centisecond after 10 run cycles, first second after 1000.
    pulse_ss();
    repeat (10) cyc();
    check("first_tick_cs", 64'(cs_o[0]), 64'd1);
    repeat (990) cyc();
    check("one_second_sec", 64'(sec_o[0]), 64'd1);
    check("one_second_cs", 64'(cs_o[0]), 64'd0);

    // Pause preserves divider phase.
    do_reset();
    pulse_ss();
    repeat (250) cyc();
    pulse_ss();
    repeat (100) begin
      cyc();
      check("pause_running", 64'(run_o[0]), 64'd0);
    end
    pulse_ss();
    repeat (50) cyc();
    check("pause_phase_cs", 64'(cs_o[0]), 64'd30);

    // Lap FIFO fill and overflow, then ordered drain.
    do_reset();
    pulse_ss();
    lap_ready = 1'b0;
    foreach (lap_cs[k]) begin
      w = 0;
      while (cs_o[0] != 7'(lap_cs[k]) && w < 2000) begin
        cyc();
        w++;
      end
      check("lap_wait", 64'(cs_o[0]), 64'(lap_cs[k]));
      lap = 1'b1; cyc(); lap = 1'b0;
    end
    check("lap_overflow_set", 64'(ovf_o[0]), 64'd1);
    lap_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("lap_order", 64'(data_o[0][6:0]), 64'(lap_cs[k]));
      cyc();
    end
    check("lap_drained", 64'(val_o[0]), 64'd0);
    lap_ready = 1'b0;

    // Clear with empty FIFO drops overflow; full FIFO with simultaneous push and pop.
    clear = 1'b1; cyc(); clear = 1'b0;
    check("ovf_cleared", 64'(ovf_o[0]), 64'd0);
    check("clear_ignored_in_run", 64'(run_o[0]), 64'd1);
    lap = 1'b1;
    repeat (4) cyc();
    lap_ready = 1'b1;
    cyc();
    lap = 1'b0;
    check("full_push_pop_ovf", 64'(ovf_o[0]), 64'd0);
    check("full_push_pop_valid", 64'(val_o[0]), 64'd1);
    repeat (4) cyc();
    check("full_push_pop_drain", 64'(val_o[0]), 64'd0);
    lap_ready = 1'b0;

    // Clear wins over start_stop in PAUSE; reset mid-run.
    pulse_ss();
    repeat (3) cyc();
    clear = 1'b1; start_stop = 1'b1; cyc(); clear = 1'b0; start_stop = 1'b0;
    check("clear_wins_running", 64'(run_o[0]), 64'd0);
    check("clear_wins_counts", {43'd0, min_o[0], sec_o[0], cs_o[0]}, 64'd0);
    pulse_ss();
    repeat (37) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    check("reset_mid_run", obs(0), 64'd0);

    // Random traffic.
    repeat (3000) begin
      start_stop = ($urandom_range(0, 39) == 0);
      clear      = ($urandom_range(0, 29) == 0);
      lap        = ($urandom_range(0, 5) == 0);
      lap_ready  = ($urandom_range(0, 2) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      cyc();
    end
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0; lap_ready = 1'b0; rst = 1'b0;

    // Long run: saturation on cfg2 at 6000 ticks, wrap on cfg1 at 12000 ticks.
    do_reset();
    pulse_ss();
    lap_ready = 1'b1;
    repeat (6000) begin
      lap = ($urandom_range(0, 399) == 0);
      cyc();
    end
    lap = 1'b0;
    check("sat_counts", {43'd0, min_o[2], sec_o[2], cs_o[2]}, {43'd0, 7'd0, 7'd59, 7'd99});
    check("sat_max_flag", 64'(max_o[2]), 64'd1);
    check("sat_paused", 64'(run_o[2]), 64'd0);
    repeat (6000) begin
      lap = ($urandom_range(0, 399) == 0);
      cyc();
    end
    lap = 1'b0;
    check("wrap_counts", {43'd0, min_o[1], sec_o[1], cs_o[1]}, 64'd0);
    check("wrap_max_flag", 64'(max_o[1]), 64'd1);
    check("wrap_running", 64'(run_o[1]), 64'd1);
    pulse_ss();
    check("sat_start_ignored", 64'(run_o[2]), 64'd0);
    clear = 1'b1; cyc(); clear = 1'b0;
    check("sat_clear_counts", {43'd0, min_o[2], sec_o[2], cs_o[2]}, 64'd0);
    check("sat_clear_max", 64'(max_o[2]), 64'd0);
    repeat (5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
Parametrised successor to the single-channel stopwatch. Counts centiseconds, seconds and minutes from an internal tick divider. Adds a run/pause/idle control FSM, configurable rollover (wrap or saturate) and a lap-capture FIFO with a valid/ready read interface. Sits beside the clock and alarm blocks and feeds the display mux and lap-readout logic.

Parameters:
CLK_FREQ_HZ, 50000000, input clock frequency; must be an integer multiple of 100.
MIN_W, 7, width of the minute counter.
MIN_MAX, 59, last minute value before rollover; must be at most 2^MIN_W-1.
SATURATE, 0, 0 wraps to 00:00.00 and keeps running; 1 holds at maximum.
LAP_DEPTH, 4, number of lap FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_stop  in  1  single-cycle pulse; toggles run/pause
clear  in  1  single-cycle pulse; zeroes the count when not running
lap  in  1  single-cycle pulse; captures the current time into the FIFO
cs_count  out  7  centiseconds, 0..99
sec_count  out  7  seconds, 0..59
min_count  out  MIN_W  minutes, 0..MIN_MAX
running  out  1  high in the RUN state
max_flag  out  1  sticky; set when the count reaches or passes maximum
lap_valid  out  1  FIFO not empty
lap_ready  in  1  consumer pops the head entry when lap_valid and lap_ready
lap_data  out  14+MIN_W  head entry, packed as {min, sec, cs}
lap_overflow  out  1  sticky; a lap was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All counts, the divider, the FIFO pointers, max_flag and lap_overflow clear to 0.
  - running=0, lap_valid=0, lap_data=0.
  - Reset overrides all other inputs in the same cycle.
- Divider:
  - DIV = CLK_FREQ_HZ/100.
  - The divider counts 0..DIV-1 only in RUN.
  - tick is asserted internally on the cycle the divider is at DIV-1.
  - The divider is held in PAUSE, so fractional progress is preserved.
  - The divider is zeroed in IDLE.
- Counting:
  - On tick, cs increments.
  - At 99, cs wraps to 0 and sec increments.
  - At 59, sec wraps to 0 and min increments.
  - All counts are registered; they update the edge after tick.
- Rollover, on a tick at MIN_MAX:59.99:
  - SATURATE=0: all counts go to 0, max_flag is set, and the FSM stays in RUN.
  - SATURATE=1: counts hold at MIN_MAX:59.99, max_flag is set, and the FSM goes to PAUSE.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE to RUN on start_stop.
  - RUN to PAUSE on start_stop.
  - PAUSE to RUN on start_stop, except with SATURATE=1 while max_flag=1, where the pulse is ignored.
  - PAUSE to IDLE on clear; this zeroes counts, the divider and max_flag. The FIFO is untouched.
  - clear is ignored in RUN and in IDLE.
  - If clear and start_stop arrive together in PAUSE, clear wins and the FSM goes to IDLE.
- Lap capture:
  - lap is accepted only in RUN or PAUSE.
  - The snapshot is the count values registered in that cycle, i.e. before any tick update in the same cycle.
  - A push while full, with no simultaneous pop, drops the lap and sets lap_overflow.
  - A push while full with a simultaneous pop is accepted.
  - A push and a pop together when not full leave the occupancy unchanged.
  - lap_overflow clears only on rst, or on clear when the FIFO is empty.
- FIFO read:
  - lap_data is valid whenever lap_valid=1.
  - The pop takes effect at the edge where lap_valid and lap_ready are both high.
  - lap_data reflects the new head on the next cycle.
  - Lap data is first-in first-out, and the FIFO is independent of the FSM state.
- start_stop together with lap in RUN: the lap is captured with the current counts, and the FSM goes to PAUSE.

Optional Feature:
Macro: LAP_STOPWATCH_SPLIT_EN.
- Defined:
  - lap_data stores the split time instead of the absolute time. The split is the elapsed time since the previous accepted lap, or since IDLE for the first lap.
  - Split arithmetic uses mixed-radix subtraction with borrows across cs (radix 100), sec (radix 60) and min.
  - After a SATURATE=0 wrap, the split is computed modulo (MIN_MAX+1) minutes.
  - The reference snapshot resets in IDLE.
- Undefined: lap_data holds the absolute time, and no subtractor is instantiated.

Test Plan:
1. CLK_FREQ_HZ=1000 (DIV=10), rst, then start_stop -> cs_count=1 after 10 cycles; after 1000 cycles, sec_count=1 and cs_count=0.
2. Run 250 cycles, start_stop, wait 100 cycles, start_stop, run 50 cycles -> cs_count=30; running=0 throughout the pause; the divider phase is preserved.
3. MIN_MAX=1, SATURATE=0, run to 01:59.99 and apply one tick -> all counts 0, max_flag=1, running=1. With SATURATE=1 -> counts hold at 01:59.99, FSM in PAUSE, a later start_stop is ignored, clear returns to 00:00.00 with max_flag=0.
4. LAP_DEPTH=4, lap at cs=5, 12, 20, 33, 41 with lap_ready=0 -> four entries held and lap_overflow=1. Then hold lap_ready=1 -> lap_data shows cs 5, 12, 20, 33 in order, then lap_valid=0.
5. FIFO full, lap and lap_ready in the same cycle -> occupancy stays 4, no overflow, the new entry is at the tail.
6. In PAUSE, clear together with start_stop -> IDLE with counts 0. rst asserted mid-RUN -> all outputs 0 on the next edge.
